// File: rtl/hdmi_tx_pkg.sv
`default_nettype none
// ============================================================================
//  hdmi_tx_pkg
//  Shared types and constants for the HDMI/DVI video transmitter:
//  TMDS control tokens, HDMI video guard-band words, the period type
//  carried down the alignment pipeline, and the pipeline control record.
//  Revision: 1.0  initial release
// ============================================================================
package hdmi_tx_pkg;

  // Kind of symbol a channel emits in a given aligned cycle.
  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } period_t;

  // Control record that travels alongside a pixel request.
  typedef struct packed {
    period_t period;
    logic    hsync;   // polarity already applied
    logic    vsync;   // polarity already applied
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{period: CTRL, hsync: 1'b0, vsync: 1'b0};

  // Control tokens indexed by the 2-bit control data {C1,C0}.
  localparam logic [9:0] CTRL_TOKEN [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  // Video data-period guard band words.
  localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
  localparam logic [9:0] GUARD_CH2 = 10'b1011001100;

endpackage
`default_nettype wire

// File: rtl/tmds_channel_enc.sv
`default_nettype none
// ============================================================================
//  tmds_channel_enc
//  One TMDS channel: 8b/10b transition-minimised, DC-balanced video encode,
//  control-token and guard-band emission. Owns the running disparity and
//  the registered 10-bit output word.
//  Ports:
//    pixclk, reset  clock / asynchronous active-high reset
//    period         symbol kind for this cycle (CTRL/PREAMBLE/GUARD/VIDEO)
//    d[7:0]         pixel component (used in VIDEO)
//    cd[1:0]        control data (used in CTRL/PREAMBLE)
//    guard[9:0]     guard-band word for this channel
//    q[9:0]         encoded word, LSB transmitted first
//  Revision: 1.0  initial release
// ============================================================================
module tmds_channel_enc
  import hdmi_tx_pkg::*;
(
  input  logic        pixclk,
  input  logic        reset,
  input  period_t     period,
  input  logic [7:0]  d,
  input  logic [1:0]  cd,
  input  logic [9:0]  guard,
  output logic [9:0]  q
);

  // Running disparity, 5-bit two's complement (bit 4 is the sign).
  logic [4:0] cnt;
  logic [4:0] cnt_nx;
  logic [9:0] word;

  always_comb begin
    logic [3:0] n1d;
    logic [3:0] n1q;
    logic       use_xnor;
    logic [8:0] t;
    logic [4:0] diff;

    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
    // Tie at four ones resolves to XNOR when d[0] is 0.
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);

    t    = '0;
    t[0] = d[0];
    for (int i = 1; i < 8; i++)
      t[i] = use_xnor ? ~(t[i-1] ^ d[i]) : (t[i-1] ^ d[i]);
    t[8] = ~use_xnor;

    n1q = '0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, t[i]};
    // diff = N1 - N0 of q_m[7:0] = 2*N1 - 8
    diff = {n1q, 1'b0} - 5'd8;

    word   = {1'b0, t[8], t[7:0]};
    cnt_nx = cnt;
    if ((cnt == 5'd0) || (n1q == 4'd4)) begin
      word   = {~t[8], t[8], t[8] ? t[7:0] : ~t[7:0]};
      cnt_nx = t[8] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[4] && (n1q > 4'd4)) || (cnt[4] && (n1q < 4'd4))) begin
      word   = {1'b1, t[8], ~t[7:0]};
      cnt_nx = cnt + {3'b000, t[8], 1'b0} - diff;
    end else begin
      word   = {1'b0, t[8], t[7:0]};
      cnt_nx = cnt - {3'b000, ~t[8], 1'b0} + diff;
    end
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      q   <= CTRL_TOKEN[0];
      cnt <= '0;
    end else begin
      case (period)
        VIDEO: begin
          q   <= word;
          cnt <= cnt_nx;
        end
        GUARD: begin
          q   <= guard;
          cnt <= '0;
        end
        default: begin
          q   <= CTRL_TOKEN[cd];
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hdmi_video_tx.sv
`default_nettype none
// ============================================================================
//  hdmi_video_tx
//  Raster timing generator plus three TMDS channel encoders. Requests
//  pixels by coordinate, aligns the control stream to the returned pixel
//  data, and emits 10-bit TMDS words per channel. Optional HDMI mode adds
//  the 8-cycle video preamble and 2-cycle guard band before active lines.
//  Ports:
//    pixclk, reset         clock / asynchronous active-high reset
//    req_x, req_y          coordinate of the requested pixel
//    req_de                pixel request strobe
//    frame_start           one-cycle pulse at (0,0)
//    pix_r/g/b             pixel data, PIX_LAT cycles after req_de
//    tmds_ch0/1/2          encoded words (blue+sync, green, red)
//  Revision: 1.0  initial release
// ============================================================================
module hdmi_video_tx
  import hdmi_tx_pkg::*;
#(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   HDMI_MODE = 1,
  parameter int   PIX_LAT   = 1,
  localparam int  H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  CW        = $clog2((H_TOT > V_TOT) ? H_TOT : V_TOT)
)(
  input  logic          pixclk,
  input  logic          reset,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          req_de,
  output logic          frame_start,
  input  logic [7:0]    pix_r,
  input  logic [7:0]    pix_g,
  input  logic [7:0]    pix_b,
  output logic [9:0]    tmds_ch0,
  output logic [9:0]    tmds_ch1,
  output logic [9:0]    tmds_ch2
);

  // The preamble+guard window is the last 10 cycles of the line, which
  // sits in the back porch; it must not reach back into the hsync pulse.
  if ((HDMI_MODE != 0) && (H_BP < 10)) begin : g_bad_porch
    $error("hdmi_video_tx: back porch too short for preamble and guard band");
  end
  if ((PIX_LAT < 1) || (PIX_LAT > 4)) begin : g_bad_lat
    $error("hdmi_video_tx: PIX_LAT must be in 1..4");
  end

  localparam logic [CW-1:0] X_LAST    = CW'(H_TOT - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(V_TOT - 1);
  localparam logic [CW-1:0] HA        = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA        = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VA_M1     = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] PRE_START = CW'(H_TOT - 10);
  localparam logic [CW-1:0] GRD_START = CW'(H_TOT - 2);

  // cx/cy point at the position that will be presented on req_* next.
  logic [CW-1:0] cx, cy;
  logic          w_de;
  logic          w_nl_act;
  ctrl_t         w_ctrl;
  ctrl_t         pipe [0:PIX_LAT];

  always_comb begin
    w_de = (cx < HA) && (cy < VA);
    // Next line is active; the last line of the frame precedes line 0,
    // so line 0 also gets its preamble and guard band.
    w_nl_act = (cy == Y_LAST) || (cy < VA_M1);

    w_ctrl       = CTRL_IDLE;
    w_ctrl.hsync = ((cx >= HS_START) && (cx < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    w_ctrl.vsync = ((cy >= VS_START) && (cy < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    if (w_de)
      w_ctrl.period = VIDEO;
    else if ((HDMI_MODE != 0) && w_nl_act && (cx >= GRD_START))
      w_ctrl.period = GUARD;
    else if ((HDMI_MODE != 0) && w_nl_act && (cx >= PRE_START))
      w_ctrl.period = PREAMBLE;
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      cx          <= '0;
      cy          <= '0;
      req_x       <= '0;
      req_y       <= '0;
      req_de      <= 1'b0;
      frame_start <= 1'b0;
      for (int i = 0; i <= PIX_LAT; i++) pipe[i] <= CTRL_IDLE;
    end else begin
      req_x       <= cx;
      req_y       <= cy;
      req_de      <= w_de;
      frame_start <= (cx == '0) && (cy == '0);
      // pipe[0] lines up with req_*, pipe[PIX_LAT] with pix_*.
      pipe[0] <= w_ctrl;
      for (int i = 1; i <= PIX_LAT; i++) pipe[i] <= pipe[i-1];
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  ctrl_t      al;
  logic [1:0] cd0, cd1;

  assign al  = pipe[PIX_LAT];
  assign cd0 = {al.vsync, al.hsync};
  assign cd1 = (al.period == PREAMBLE) ? 2'b01 : 2'b00;

  tmds_channel_enc u_enc0 (
    .pixclk (pixclk), .reset (reset), .period (al.period),
    .d (pix_b), .cd (cd0), .guard (GUARD_CH0), .q (tmds_ch0)
  );
  tmds_channel_enc u_enc1 (
    .pixclk (pixclk), .reset (reset), .period (al.period),
    .d (pix_g), .cd (cd1), .guard (GUARD_CH1), .q (tmds_ch1)
  );
  tmds_channel_enc u_enc2 (
    .pixclk (pixclk), .reset (reset), .period (al.period),
    .d (pix_r), .cd (2'b00), .guard (GUARD_CH2), .q (tmds_ch2)
  );

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_tx.sv
`default_nettype none
// ============================================================================
//  tb_hdmi_video_tx
//  Scoreboard bench for hdmi_video_tx on a reduced raster in HDMI mode with
//  inverted hsync polarity and PIX_LAT=3. Random pixels; expected request
//  tuples and TMDS words come from a raster/encoding model and are queued
//  with their due cycle; a separate monitor pops and compares.
//  Revision: 1.0  initial release
// ============================================================================
module tb_hdmi_video_tx;

  localparam int   HA = 16, HF = 2, HS = 4, HB = 12;
  localparam int   VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FRAME = HT * VT;
  localparam int   PL = 3;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b1;
  localparam int   CW = $clog2((HT > VT) ? HT : VT);

  logic          pixclk = 1'b0;
  logic          reset  = 1'b1;
  logic [CW-1:0] req_x, req_y;
  logic          req_de, frame_start;
  logic [7:0]    pix_r = 8'h00, pix_g = 8'h00, pix_b = 8'h00;
  logic [9:0]    tmds_ch0, tmds_ch1, tmds_ch2;

  hdmi_video_tx #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HSYNC_POL (HPOL), .VSYNC_POL (VPOL), .HDMI_MODE (1), .PIX_LAT (PL)
  ) dut (
    .pixclk (pixclk), .reset (reset),
    .req_x (req_x), .req_y (req_y), .req_de (req_de), .frame_start (frame_start),
    .pix_r (pix_r), .pix_g (pix_g), .pix_b (pix_b),
    .tmds_ch0 (tmds_ch0), .tmds_ch1 (tmds_ch1), .tmds_ch2 (tmds_ch2)
  );

  always #5 pixclk = ~pixclk;

  int cyc = 0;
  always @(posedge pixclk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t        rq[$];
  exp_t        tq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pos = 0;
  int          disp [3] = '{0, 0, 0};
  logic [23:0] hist [0:PL];

  function automatic logic [9:0] tok(input int cd);
    case (cd)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // TMDS video encode with running disparity kept as a plain integer.
  function automatic logic [9:0] enc(input logic [7:0] d, input int cin, output int cout);
    logic [8:0] qm;
    bit         xn, inv;
    int         ones, zeros, v;
    xn    = ($countones(d) > 4) || (($countones(d) == 4) && (d[0] == 1'b0));
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    ones  = $countones(qm[7:0]);
    zeros = 8 - ones;
    if ((cin == 0) || (ones == zeros)) begin
      inv = !qm[8];
      v   = cin + (qm[8] ? (ones - zeros) : (zeros - ones));
    end else if (((cin > 0) && (ones > zeros)) || ((cin < 0) && (zeros > ones))) begin
      inv = 1'b1;
      v   = cin + 2 * int'(qm[8]) + zeros - ones;
    end else begin
      inv = 1'b0;
      v   = cin - 2 * int'(!qm[8]) + ones - zeros;
    end
    cout = (((v + 16) % 32) + 32) % 32 - 16;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  // One stimulus cycle: drive the pixel that answers the request from PL
  // cycles ago, and when live, queue the expectations for this position.
  task automatic step(input bit live);
    logic [23:0] px;
    logic [29:0] t;
    int          x, y, c;
    bit          de, nla, hs, vs;
    exp_t        e;
    case ($urandom_range(0, 7))
      0:       px = 24'h000000;
      1:       px = 24'hFFFFFF;
      default: px = 24'($urandom);
    endcase
    for (int i = PL; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = px;
    {pix_r, pix_g, pix_b} = hist[PL];
    if (!live) return;

    x   = pos % HT;
    y   = pos / HT;
    de  = (x < HA) && (y < VA);
    nla = ((y + 1) % VT) < VA;
    hs  = ((x >= HA + HF) && (x < HA + HF + HS)) ? HPOL : !HPOL;
    vs  = ((y >= VA + VF) && (y < VA + VF + VS)) ? VPOL : !VPOL;

    e.due = cyc;
    e.val = 32'({de, (pos == 0), CW'(x), CW'(y)});
    rq.push_back(e);

    if (de) begin
      t[9:0]   = enc(px[7:0],   disp[0], c); disp[0] = c;
      t[19:10] = enc(px[15:8],  disp[1], c); disp[1] = c;
      t[29:20] = enc(px[23:16], disp[2], c); disp[2] = c;
    end else begin
      disp = '{0, 0, 0};
      if (nla && (x >= HT - 2))
        t = {10'b1011001100, 10'b0100110011, 10'b1011001100};
      else if (nla && (x >= HT - 10))
        t = {tok(0), tok(1), tok(int'({vs, hs}))};
      else
        t = {tok(0), tok(0), tok(int'({vs, hs}))};
    end
    e.due = cyc + PL + 1;
    e.val = 32'(t);
    tq.push_back(e);
    pos = (pos + 1) % FRAME;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor: sample mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge pixclk);
      #2;
      if (reset) begin
        check("reset_tmds", 32'({tmds_ch2, tmds_ch1, tmds_ch0}), 32'({3{10'h354}}));
        check("reset_req", 32'({req_de, frame_start, req_x, req_y}), 32'h0);
      end else begin
        while ((rq.size() > 0) && (rq[0].due <= cyc)) begin
          e = rq.pop_front();
          check((e.due == cyc) ? "req" : "req_stale",
                32'({req_de, frame_start, req_x, req_y}), e.val);
        end
        while ((tq.size() > 0) && (tq[0].due <= cyc)) begin
          e = tq.pop_front();
          check((e.due == cyc) ? "tmds" : "tmds_stale",
                32'({tmds_ch2, tmds_ch1, tmds_ch0}), e.val);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i <= PL; i++) hist[i] = '0;
    repeat (5) @(negedge pixclk);
    reset = 1'b0;
    repeat (FRAME + 2 * HT + 7) begin
      @(negedge pixclk);
      step(1'b1);
    end

    // Mid-line reset, held for 5 cycles, then a clean restart at (0,0).
    @(negedge pixclk);
    reset = 1'b1;
    rq.delete();
    tq.delete();
    repeat (5) @(negedge pixclk);
    reset = 1'b0;
    pos   = 0;
    disp  = '{0, 0, 0};
    repeat (2 * FRAME + 10) begin
      @(negedge pixclk);
      step(1'b1);
    end
    repeat (PL + 3) begin
      @(negedge pixclk);
      step(1'b0);
    end
    @(negedge pixclk);
    #4;
    check("drain", 32'(rq.size() + tq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
